interface_tx: RTL and testbench
===============================

Name: interface_tx

Overview:
- Transmit-side companion of the ALU UART front end.
- Latches an 8-bit ALU result on a start pulse and converts it to three ASCII decimal digits with a sequential double-dabble.
- Streams a 5-character frame, one byte per UART transmitter handshake: 'r' (114), hundreds, tens, units, LF (10).
- Sits between the ALU result register and the UART tx module (tx_start/din/tx_done_tick).

Parameters:
- DBIT, 8, result width in bits; fixed at 8 for this revision.
- NDIG, 3, decimal digits emitted; must satisfy 10^NDIG > 2^DBIT-1.
- HDR_CHAR, 114, ASCII frame header 'r'.
- END_CHAR, 10, ASCII frame terminator LF.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request to send result; honoured only in IDLE.
- result  input  DBIT  unsigned ALU result; sampled on the cycle start is accepted.
- tx_done_tick  input  1  one-cycle pulse from the UART tx when a byte has finished.
- tx_start  output  1  one-cycle pulse to the UART tx to begin sending din.
- din  output  8  byte to transmit; held stable from tx_start until the matching tx_done_tick.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done_tick  output  1  one-cycle pulse after the terminator's tx_done_tick.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tx_start, busy and done_tick = 0; din = 0.
  - BCD, shift and character-index registers cleared.
  - Reset mid-frame aborts immediately; no further tx_start is issued.
- State machine: IDLE, CONVERT, SEND, WAIT, DONE. All registers are clocked; next-state logic is combinational.
- IDLE:
  - On start=1: latch result into the shift register, clear BCD, set bit counter to DBIT, go to CONVERT.
  - tx_done_tick is ignored.
- CONVERT, one bit per cycle (double-dabble):
  - Each BCD nibble >=5 gets +3.
  - Then shift {bcd, shreg} left by 1 and decrement the counter.
  - Takes exactly DBIT cycles, then go to SEND with char index 0.
- SEND:
  - Drive din per index: 0 -> HDR_CHAR; 1..NDIG -> 48 + digit (most significant first); NDIG+1 -> END_CHAR.
  - Assert tx_start for exactly this one cycle, then go to WAIT.
- WAIT:
  - Hold din.
  - On tx_done_tick: if index = NDIG+1, go to DONE; otherwise increment index and go to SEND.
- DONE: done_tick=1 for one cycle, then IDLE.
- Latency: first tx_start occurs DBIT+1 cycles after the start-accept edge. Every later tx_start occurs 1 cycle after the previous tx_done_tick.
- Leading zeros are always sent: exactly 3 digits, matching the rx-side 3-digit operand format.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - result changing after acceptance: no effect on the current frame.
  - tx_done_tick outside WAIT: ignored.
  - start in the same cycle as DONE: ignored; the next start is accepted in IDLE.
- busy=1 in CONVERT, SEND, WAIT and DONE.

Decomposition:
- Shared package (uart_pkg) holds:
  - state encodings IDLE..DONE (3 bits);
  - ASCII constants ASCII_ZERO=48, HDR_CHAR=114, END_CHAR=10;
  - the rx-side opcode letters 'f', 'r', 'o', 'd', for consistency.
- One natural sub-module: bin2bcd_seq. It holds the DBIT-cycle double-dabble, with ports start/done/bin/bcd. The FSM instantiates it and waits on its done.

Test Plan:
- result=0, start pulse; UART model returns tx_done_tick 10 cycles after each tx_start -> din sequence 114,48,48,48,10.
  - Exactly 5 tx_start pulses.
  - First tx_start 9 cycles after start.
  - done_tick once.
- result=255 -> 114,50,53,53,10. result=123 -> 114,49,50,51,10. result=7 -> 114,48,48,55,10.
- start=1 again with result=99 during WAIT of char 2 -> frame unchanged (123); no second frame.
  - A start after done_tick sends 114,48,57,57,10.
- tx_done_tick pulsed in IDLE and during CONVERT -> no tx_start, no state change.
  - din stays stable between each tx_start and its tx_done_tick.
- reset=0 for 1 cycle during WAIT of char 3 -> tx_start, busy and done_tick all 0 immediately, state IDLE.
  - No further tx_start until a new start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the ALU UART front end.
// Holds the transmit FSM state encoding, ASCII frame constants, the rx-side
// opcode letters and a small helper that turns a BCD digit into ASCII.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } tx_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] HDR_CHAR   = 8'd114;  // 'r'
  localparam logic [7:0] END_CHAR   = 8'd10;   // LF

  // Opcode letters understood by the receive side.
  localparam logic [7:0] OP_F = 8'd102;  // 'f'
  localparam logic [7:0] OP_R = 8'd114;  // 'r'
  localparam logic [7:0] OP_O = 8'd111;  // 'o'
  localparam logic [7:0] OP_D = 8'd100;  // 'd'

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/interface_tx_bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per cycle.
// Ports:
//   clk, reset  clock (rising edge), asynchronous active-low reset
//   start       load bin and begin a DBIT-cycle conversion
//   bin         unsigned binary input, sampled with start
//   done        high in the cycle whose closing edge performs the last shift,
//               so bcd is final from the following cycle onward
//   bcd         NDIG packed BCD digits, held after conversion
module bin2bcd_seq #(
  parameter int DBIT = 8,
  parameter int NDIG = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DBIT-1:0]       bin,
  output logic                  done,
  output logic [4*NDIG-1:0]     bcd
);

  localparam int CW = $clog2(DBIT + 1);

  logic [DBIT-1:0]   r_sh;
  logic [4*NDIG-1:0] r_bcd;
  logic [CW-1:0]     r_cnt;
  logic [4*NDIG-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_sh  <= bin;
      r_bcd <= '0;
      r_cnt <= CW'(DBIT);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[4*NDIG-2:0], r_sh[DBIT-1]};
      r_sh  <= {r_sh[DBIT-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Early done lets the caller leave CONVERT on the same edge as the final
  // shift, keeping the conversion at exactly DBIT cycles.
  assign done = (r_cnt == CW'(1));
  assign bcd  = r_bcd;

endmodule

// File: rtl/interface_tx.sv
// Transmit-side companion of the ALU UART front end.
// Latches an ALU result on start, converts it to three decimal digits and
// streams the frame 'r', hundreds, tens, units, LF to the UART transmitter,
// one byte per tx_start/tx_done_tick handshake.
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-low reset
//   start         one-cycle send request, honoured only when idle
//   result        unsigned ALU result, sampled when start is accepted
//   tx_done_tick  byte-finished pulse from the UART transmitter
//   tx_start      one-cycle pulse starting transmission of din
//   din           byte to transmit, stable until its tx_done_tick
//   busy          high while a frame is in progress
//   done_tick     one-cycle pulse after the terminator has been sent
module interface_tx
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int NDIG     = 3,
  parameter int HDR_CHAR = int'(uart_pkg::HDR_CHAR),
  parameter int END_CHAR = int'(uart_pkg::END_CHAR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DBIT-1:0] result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      din,
  output logic            busy,
  output logic            done_tick
);

  localparam int IW = $clog2(NDIG + 2);

  tx_state_e         r_state, w_next;
  logic [IW-1:0]     r_idx, w_idx_next;
  logic              w_conv_start, w_conv_done;
  logic [4*NDIG-1:0] w_bcd;
  logic [7:0]        w_char;

  assign w_conv_start = (r_state == ST_IDLE) && start;

  bin2bcd_seq #(
    .DBIT (DBIT),
    .NDIG (NDIG)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_conv_start),
    .bin   (result),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  // Index 0 is the header, 1..NDIG the digits most significant first,
  // NDIG+1 the terminator.
  always_comb begin
    w_char = 8'(END_CHAR);
    if (r_idx == '0) begin
      w_char = 8'(HDR_CHAR);
    end else begin
      for (int unsigned k = 0; k < NDIG; k++) begin
        if (r_idx == IW'(NDIG - k)) begin
          w_char = digit_char(w_bcd[4*k +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    tx_start   = 1'b0;
    din        = '0;
    busy       = 1'b1;
    done_tick  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next     = ST_CONVERT;
          w_idx_next = '0;
        end
      end
      ST_CONVERT: begin
        if (w_conv_done) begin
          w_next     = ST_SEND;
          w_idx_next = '0;
        end
      end
      ST_SEND: begin
        tx_start = 1'b1;
        din      = w_char;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        din = w_char;
        if (tx_done_tick) begin
          if (r_idx == IW'(NDIG + 1)) begin
            w_next = ST_DONE;
          end else begin
            w_idx_next = r_idx + IW'(1);
            w_next     = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        done_tick = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interface_tx.sv
// Self-checking bench for interface_tx: a UART transmitter model answers each
// tx_start with tx_done_tick, and a compare process checks every transmitted
// byte against a decimal frame model and checks din stability.
module tb_interface_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] result;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       busy;
  logic       done_tick;

  logic tick_model  = 1'b0;
  logic tick_manual = 1'b0;
  assign tx_done_tick = tick_model | tick_manual;

  interface_tx #(
    .DBIT     (8),
    .NDIG     (3),
    .HDR_CHAR (114),
    .END_CHAR (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .result       (result),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .din          (din),
    .busy         (busy),
    .done_tick    (done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: byte finishes 10 cycles after tx_start.
  always begin
    @(negedge clk);
    if (tx_start) begin
      repeat (9) @(posedge clk);
      #1 tick_model = 1'b1;
      @(posedge clk);
      #1 tick_model = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_pass = 0;
  int n_tot  = 0;
  int exp_r  = 0;
  int frames_req = 0;
  int n_done = 0;
  int tx_cycles[$];
  int cap[$];

  function automatic int model_byte(input int r, input int k);
    case (k)
      0:       return 114;
      1:       return 48 + r / 100;
      2:       return 48 + (r / 10) % 10;
      3:       return 48 + r % 10;
      4:       return 10;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done_tick) ok = 1'b1;
    end
    #1;
  endtask

  task automatic run_frame(input int r, input logic [39:0] lit,
                           input bit conv_tick, input bit busy_start);
    int st0, dn0, s_cyc;
    bit ok;
    st0 = tx_cycles.size();
    dn0 = n_done;
    exp_r = r;
    frames_req++;
    @(posedge clk);
    #1 result = 8'(r); start = 1'b1; s_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0; result = 8'hA5;
    chk("busy_after_accept", int'(busy), 1);
    if (conv_tick) begin
      repeat (3) @(posedge clk);
      #1 tick_manual = 1'b1;
      @(posedge clk);
      #1 tick_manual = 1'b0;
    end
    if (busy_start) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(posedge clk);
        if (tx_cycles.size() - st0 >= 3) ok = 1'b1;
      end
      chk("reach_char2", int'(ok), 1);
      repeat (4) @(posedge clk);
      #1 start = 1'b1; result = 8'd99;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(400, ok);
    chk("done_seen", int'(ok), 1);
    chk("tx_start_count", tx_cycles.size() - st0, 5);
    chk("done_count", n_done - dn0, 1);
    if (tx_cycles.size() > st0) chk("first_latency", tx_cycles[st0] - s_cyc, 9);
    for (int k = 0; k < 5; k++) begin
      if (st0 + k < cap.size()) chk($sformatf("lit_byte%0d", k), cap[st0 + k], int'(lit[39 - 8*k -: 8]));
      else chk($sformatf("lit_missing%0d", k), 0, 1);
    end
  endtask

  initial begin
    int st, started, k, held;
    bit pending, ok;
    reset = 1'b0; start = 1'b0; result = '0;

    // Compare process: every transmitted byte must follow the frame model.
    fork
      begin
        started = 0; k = 0; held = 0; pending = 1'b0;
        forever begin
          @(negedge clk);
          if (!reset) begin
            k = 0;
            pending = 1'b0;
          end else begin
            if (tx_start) begin
              tx_cycles.push_back(cyc);
              cap.push_back(int'(din));
              if (k == 0) begin
                started++;
                chk("frame_requested", int'(started <= frames_req), 1);
              end
              chk($sformatf("din_r%0d_k%0d", exp_r, k), int'(din), model_byte(exp_r, k));
              held = int'(din);
              pending = 1'b1;
              k++;
            end else if (pending) begin
              chk("din_hold", int'(din), held);
            end
            if (tx_done_tick) pending = 1'b0;
            if (done_tick) begin
              n_done++;
              chk("done_after_5_chars", k, 5);
              k = 0;
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_tick", int'(done_tick), 0);
    chk("rst_din", int'(din), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // tx_done_tick while idle must not start anything.
    #1 tick_manual = 1'b1;
    @(posedge clk);
    #1 tick_manual = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_tick_busy", int'(busy), 0);
    chk("idle_tick_no_tx", tx_cycles.size(), 0);

    run_frame(0,   {8'd114, 8'd48, 8'd48, 8'd48, 8'd10}, 1'b0, 1'b0);
    run_frame(255, {8'd114, 8'd50, 8'd53, 8'd53, 8'd10}, 1'b0, 1'b0);
    run_frame(7,   {8'd114, 8'd48, 8'd48, 8'd55, 8'd10}, 1'b1, 1'b0);
    run_frame(123, {8'd114, 8'd49, 8'd50, 8'd51, 8'd10}, 1'b0, 1'b1);

    // Still in the DONE cycle: a start here must be ignored.
    st = tx_cycles.size();
    result = 8'd50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("done_cycle_start_ignored", tx_cycles.size() - st, 0);
    chk("done_cycle_busy", int'(busy), 0);

    run_frame(99, {8'd114, 8'd48, 8'd57, 8'd57, 8'd10}, 1'b0, 1'b0);

    // Reset during the wait for the units digit aborts the frame.
    st = tx_cycles.size();
    exp_r = 255;
    frames_req++;
    @(posedge clk);
    #1 result = 8'd255; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (tx_cycles.size() - st >= 4) ok = 1'b1;
    end
    chk("reach_char3", int'(ok), 1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_tx_start", int'(tx_start), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done_tick", int'(done_tick), 0);
    chk("abort_din", int'(din), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_more_tx", tx_cycles.size() - st, 4);
    chk("abort_idle", int'(busy), 0);
    if (cap.size() > st + 3) chk("abort_units_char", cap[st + 3], 53);

    run_frame(42, {8'd114, 8'd48, 8'd52, 8'd50, 8'd10}, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
